// File: rtl/pa_fspu_wb_buf_pkg.sv
//------------------------------------------------------------------------------
// Module   : pa_fspu_wb_buf_pkg
// Brief    : Shared FPU write-back types, widths and buffer depth default.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pa_fspu_wb_buf_pkg;

    localparam int c_DATA_W   = 32;
    localparam int c_REG_W    = 5;
    localparam int c_ENTRY_W  = c_REG_W + c_DATA_W;
    localparam int c_WB_DEPTH = 2;

    typedef struct packed {
        logic [c_REG_W-1:0]  reg_idx;
        logic [c_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic wb_entry_t mk_entry(input logic [c_DATA_W-1:0] data,
                                           input logic [c_REG_W-1:0]  reg_idx);
        wb_entry_t e;
        e.reg_idx = reg_idx;
        e.data    = data;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pa_fspu_wb_fifo.sv
//------------------------------------------------------------------------------
// Module   : pa_fspu_wb_fifo
// Brief    : Circular FIFO of integer write-back entries with flush.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pa_fspu_wb_fifo
    import pa_fspu_wb_buf_pkg::*;
#(
    parameter int DEPTH = c_WB_DEPTH
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  logic      i_pop,
    input  logic      i_flush,
    input  wb_entry_t i_wr_entry,
    output wb_entry_t o_head,
    output logic      o_empty,
    output logic      o_full
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          r_mem_q [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr_q, r_wr_ptr_d;
    logic [c_PTR_W-1:0] r_rd_ptr_q, r_rd_ptr_d;
    logic [c_CNT_W-1:0] r_count_q, r_count_d;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_empty   = (r_count_q == '0);
    assign o_full    = (r_count_q == c_CNT_W'(DEPTH));
    assign o_head    = r_mem_q[r_rd_ptr_q];
    assign w_push_ok = i_push && !o_full && !i_flush;
    assign w_pop_ok  = i_pop && !o_empty && !i_flush;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_comb begin
        r_wr_ptr_d = r_wr_ptr_q;
        r_rd_ptr_d = r_rd_ptr_q;
        r_count_d  = r_count_q;
        if (i_flush) begin
            r_wr_ptr_d = '0;
            r_rd_ptr_d = '0;
            r_count_d  = '0;
        end else begin
            if (w_push_ok) r_wr_ptr_d = r_wr_ptr_q + 1'b1;
            if (w_pop_ok)  r_rd_ptr_d = r_rd_ptr_q + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count_d = r_count_q + 1'b1;
                2'b01:   r_count_d = r_count_q - 1'b1;
                default: r_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_wr_ptr_q <= r_wr_ptr_d;
            r_rd_ptr_q <= r_rd_ptr_d;
            r_count_q  <= r_count_d;
            if (w_push_ok) begin
                r_mem_q[r_wr_ptr_q] <= i_wr_entry;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pa_fspu_wb_buf.sv
//------------------------------------------------------------------------------
// Module   : pa_fspu_wb_buf
// Brief    : FSPU write-back buffer: integer results queued toward RTU,
//            float results registered straight to the FPR file.
//            Optional macro FSPU_WB_BYPASS_EN: empty-FIFO zero-latency bypass.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pa_fspu_wb_buf
    import pa_fspu_wb_buf_pkg::*;
#(
    parameter int DEPTH = c_WB_DEPTH
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst,
    input  logic                fspu_ex1_rtu_wb_vld,
    input  logic [c_DATA_W-1:0] fspu_ex1_rtu_rst,
    input  logic                fspu_ex1_dp_wb_vld,
    input  logic [c_DATA_W-1:0] fspu_ex1_dp_special_result,
    input  logic [c_REG_W-1:0]  idu_fpu_ex1_dst_reg,
    input  logic                rtu_fspu_wb_grant,
    input  logic                rtu_yy_xx_flush,
    output logic                fspu_rtu_wb_vld,
    output logic [c_DATA_W-1:0] fspu_rtu_wb_data,
    output logic [c_REG_W-1:0]  fspu_rtu_wb_reg,
    output logic                fspu_fpr_wb_vld,
    output logic [c_DATA_W-1:0] fspu_fpr_wb_data,
    output logic [c_REG_W-1:0]  fspu_fpr_wb_reg,
    output logic                fspu_ctrl_full
);

    wb_entry_t w_ex1_entry;
    wb_entry_t w_head;
    logic      w_fifo_empty;
    logic      w_fifo_full;
    logic      w_push;
    logic      w_fifo_push;
    logic      w_pop;

    logic                r_fpr_vld_q,  r_fpr_vld_d;
    logic [c_DATA_W-1:0] r_fpr_data_q, r_fpr_data_d;
    logic [c_REG_W-1:0]  r_fpr_reg_q,  r_fpr_reg_d;

    assign w_ex1_entry = mk_entry(fspu_ex1_rtu_rst, idu_fpu_ex1_dst_reg);
    // A held EX1 result is re-presented by the controller, so full drops it.
    assign w_push      = fspu_ex1_rtu_wb_vld && !w_fifo_full && !rtu_yy_xx_flush;
    assign w_pop       = !w_fifo_empty && rtu_fspu_wb_grant;

`ifdef FSPU_WB_BYPASS_EN
    logic w_bypass;
    assign w_bypass         = w_fifo_empty && w_push && rtu_fspu_wb_grant;
    assign w_fifo_push      = w_push && !w_bypass;
    assign fspu_rtu_wb_vld  = !w_fifo_empty || w_bypass;
    assign fspu_rtu_wb_data = w_bypass ? w_ex1_entry.data    : w_head.data;
    assign fspu_rtu_wb_reg  = w_bypass ? w_ex1_entry.reg_idx : w_head.reg_idx;
`else
    assign w_fifo_push      = w_push;
    assign fspu_rtu_wb_vld  = !w_fifo_empty;
    assign fspu_rtu_wb_data = w_head.data;
    assign fspu_rtu_wb_reg  = w_head.reg_idx;
`endif

    assign fspu_ctrl_full = w_fifo_full;

    pa_fspu_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (forever_cpuclk),
        .rst        (cpurst),
        .i_push     (w_fifo_push),
        .i_pop      (w_pop),
        .i_flush    (rtu_yy_xx_flush),
        .i_wr_entry (w_ex1_entry),
        .o_head     (w_head),
        .o_empty    (w_fifo_empty),
        .o_full     (w_fifo_full)
    );

    // Flush only kills the valid; the data/reg capture is harmless.
    always_comb begin
        r_fpr_vld_d  = fspu_ex1_dp_wb_vld && !rtu_yy_xx_flush;
        r_fpr_data_d = r_fpr_data_q;
        r_fpr_reg_d  = r_fpr_reg_q;
        if (fspu_ex1_dp_wb_vld) begin
            r_fpr_data_d = fspu_ex1_dp_special_result;
            r_fpr_reg_d  = idu_fpu_ex1_dst_reg;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_fpr_vld_q  <= 1'b0;
            r_fpr_data_q <= '0;
            r_fpr_reg_q  <= '0;
        end else begin
            r_fpr_vld_q  <= r_fpr_vld_d;
            r_fpr_data_q <= r_fpr_data_d;
            r_fpr_reg_q  <= r_fpr_reg_d;
        end
    end

    assign fspu_fpr_wb_vld  = r_fpr_vld_q;
    assign fspu_fpr_wb_data = r_fpr_data_q;
    assign fspu_fpr_wb_reg  = r_fpr_reg_q;

endmodule

`default_nettype wire

// File: tb/tb_pa_fspu_wb_buf.sv
//------------------------------------------------------------------------------
// Module   : tb_pa_fspu_wb_buf
// Brief    : Directed and random scoreboard bench for pa_fspu_wb_buf.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pa_fspu_wb_buf;

    localparam int c_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex1_rtu_vld;
    logic [31:0] ex1_rtu_rst;
    logic        ex1_dp_vld;
    logic [31:0] ex1_dp_res;
    logic [4:0]  ex1_dst;
    logic        grant;
    logic        flush;
    logic        rtu_vld;
    logic [31:0] rtu_data;
    logic [4:0]  rtu_reg;
    logic        fpr_vld;
    logic [31:0] fpr_data;
    logic [4:0]  fpr_reg;
    logic        full;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [36:0] sb[$];
    logic        exp_fpr_vld  = 1'b0;
    logic [31:0] exp_fpr_data = '0;
    logic [4:0]  exp_fpr_reg  = '0;

    always #5 clk = ~clk;

    pa_fspu_wb_buf #(
        .DEPTH (c_DEPTH)
    ) dut (
        .forever_cpuclk             (clk),
        .cpurst                     (rst),
        .fspu_ex1_rtu_wb_vld        (ex1_rtu_vld),
        .fspu_ex1_rtu_rst           (ex1_rtu_rst),
        .fspu_ex1_dp_wb_vld         (ex1_dp_vld),
        .fspu_ex1_dp_special_result (ex1_dp_res),
        .idu_fpu_ex1_dst_reg        (ex1_dst),
        .rtu_fspu_wb_grant          (grant),
        .rtu_yy_xx_flush            (flush),
        .fspu_rtu_wb_vld            (rtu_vld),
        .fspu_rtu_wb_data           (rtu_data),
        .fspu_rtu_wb_reg            (rtu_reg),
        .fspu_fpr_wb_vld            (fpr_vld),
        .fspu_fpr_wb_data           (fpr_data),
        .fspu_fpr_wb_reg            (fpr_reg),
        .fspu_ctrl_full             (full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive EX1/RTU inputs, compare outputs against the
    // scoreboard head, then advance the reference model past the edge.
    task automatic cyc(input logic push, input logic [31:0] d, input logic [4:0] r,
                       input logic gnt, input logic fl,
                       input logic dpv, input logic [31:0] dpd, input logic [4:0] dpr);
        logic        e_vld;
        logic        e_full;
        logic        accept;
        logic        byp;
        logic [36:0] e_head;
        ex1_rtu_vld = push;
        ex1_rtu_rst = d;
        ex1_dst     = push ? r : dpr;
        grant       = gnt;
        flush       = fl;
        ex1_dp_vld  = dpv;
        ex1_dp_res  = dpd;
        if (dpv) ex1_dst = dpr;
        #1;
        e_vld  = (sb.size() != 0);
        e_full = (sb.size() == c_DEPTH);
        accept = push && !e_full && !fl;
        byp    = 1'b0;
`ifdef FSPU_WB_BYPASS_EN
        if (sb.size() == 0 && accept && gnt) begin
            byp   = 1'b1;
            e_vld = 1'b1;
        end
`endif
        chk("int_vld", 64'(rtu_vld), 64'(e_vld));
        chk("full", 64'(full), 64'(e_full));
        if (e_vld) begin
            e_head = byp ? {ex1_dst, d} : sb[0];
            chk("int_data", 64'(rtu_data), 64'(e_head[31:0]));
            chk("int_reg", 64'(rtu_reg), 64'(e_head[36:32]));
        end
        chk("fpr_vld", 64'(fpr_vld), 64'(exp_fpr_vld));
        chk("fpr_data", 64'(fpr_data), 64'(exp_fpr_data));
        chk("fpr_reg", 64'(fpr_reg), 64'(exp_fpr_reg));
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (e_vld && gnt && !byp) void'(sb.pop_front());
            if (accept && !byp) sb.push_back({ex1_dst, d});
        end
        exp_fpr_vld = dpv && !fl;
        if (dpv) begin
            exp_fpr_data = dpd;
            exp_fpr_reg  = dpr;
        end
        #1;
    endtask

    task automatic ipush(input logic [31:0] d, input logic [4:0] r, input logic gnt);
        cyc(1'b1, d, r, gnt, 1'b0, 1'b0, 32'h0, 5'd0);
    endtask

    task automatic idle(input logic gnt);
        cyc(1'b0, 32'h0, 5'd0, gnt, 1'b0, 1'b0, 32'h0, 5'd0);
    endtask

    initial begin
        rst         = 1'b1;
        ex1_rtu_vld = 1'b1;
        ex1_rtu_rst = 32'hDEAD_BEEF;
        ex1_dst     = 5'd9;
        ex1_dp_vld  = 1'b1;
        ex1_dp_res  = 32'h1234_5678;
        grant       = 1'b1;
        flush       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_int_vld", 64'(rtu_vld), 64'd0);
        chk("rst_int_data", 64'(rtu_data), 64'd0);
        chk("rst_int_reg", 64'(rtu_reg), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_fpr_vld", 64'(fpr_vld), 64'd0);
        chk("rst_fpr_data", 64'(fpr_data), 64'd0);

        // Inputs seen only in the reset cycle must not surface.
        idle(1'b0);
        idle(1'b1);

        // Single push, granted next cycle.
        ipush(32'h0000_0200, 5'd5, 1'b1);
        chk("lat1_vld", 64'(rtu_vld), 64'd1);
        chk("lat1_data", 64'(rtu_data), 64'h200);
        chk("lat1_reg", 64'(rtu_reg), 64'd5);
        idle(1'b1);
        idle(1'b0);

        // Fill, overflow attempt, drain in order.
        ipush(32'h1, 5'd1, 1'b0);
        ipush(32'h2, 5'd2, 1'b0);
        chk("full_after2", 64'(full), 64'd1);
        ipush(32'h3, 5'd3, 1'b0);
        ipush(32'h3, 5'd3, 1'b1);
        chk("head_b", 64'(rtu_data), 64'h2);
        idle(1'b0);
        idle(1'b1);
        chk("drained", 64'(rtu_vld), 64'd0);
        idle(1'b0);

        // Simultaneous push and pop at count 1.
        ipush(32'hD, 5'd13, 1'b0);
        ipush(32'hE, 5'd14, 1'b1);
        chk("pp_full", 64'(full), 64'd0);
        chk("pp_head", 64'(rtu_data), 64'hE);
        idle(1'b1);
        idle(1'b0);

        // Flush with push while two entries held.
        ipush(32'hF, 5'd15, 1'b0);
        ipush(32'h10, 5'd16, 1'b0);
        cyc(1'b1, 32'h11, 5'd17, 1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        chk("flush_vld", 64'(rtu_vld), 64'd0);
        chk("flush_full", 64'(full), 64'd0);
        idle(1'b0);
        ipush(32'h20, 5'd20, 1'b0);
        cyc(1'b0, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0, 5'd0);
        idle(1'b1);

        // Float path, plain and under flush.
        cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 5'd3);
        chk("fpr_vld_lit", 64'(fpr_vld), 64'd1);
        chk("fpr_data_lit", 64'(fpr_data), 64'h8000_0000);
        chk("fpr_reg_lit", 64'(fpr_reg), 64'd3);
        cyc(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 5'd3);
        chk("fpr_flush_vld", 64'(fpr_vld), 64'd0);
        idle(1'b0);
        chk("fpr_hold_data", 64'(fpr_data), 64'h8000_0000);

        // Push with grant into an empty FIFO.
        ipush(32'hABCD, 5'd7, 1'b1);
        idle(1'b1);
        idle(1'b0);

        for (int i = 0; i < 300; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, 5'($urandom),
                1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0),
                1'($urandom_range(0, 1)), $urandom, 5'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pa_fspu_wb_buf.md
PA_FSPU_WB_BUF -- requirements
Module: pa_fspu_wb_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, integer-result buffer entries (power of two, >=2).
REQ-002 SHALL have port forever_cpuclk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port cpurst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port fspu_ex1_rtu_wb_vld  input  1  EX1 integer-destination result valid (fclass, fmv.x.w).
REQ-005 SHALL have port fspu_ex1_rtu_rst  input  32  EX1 integer result.
REQ-006 SHALL have port fspu_ex1_dp_wb_vld  input  1  EX1 float-destination result valid (fsgnj*, fmv.w.x).
REQ-007 SHALL have port fspu_ex1_dp_special_result  input  32  EX1 float result.
REQ-008 SHALL have port idu_fpu_ex1_dst_reg  input  5  EX1 destination register index.
REQ-009 SHALL have port rtu_fspu_wb_grant  input  1  RTU accepts integer write-back this cycle.
REQ-010 SHALL have port rtu_yy_xx_flush  input  1  pipeline flush.
REQ-011 SHALL have port fspu_rtu_wb_vld  output  1  integer write-back request.
REQ-012 SHALL have port fspu_rtu_wb_data  output  32  integer write-back data.
REQ-013 SHALL have port fspu_rtu_wb_reg  output  5  integer write-back index.
REQ-014 SHALL have port fspu_fpr_wb_vld  output  1  FPR write enable.
REQ-015 SHALL have port fspu_fpr_wb_data  output  32  FPR write data.
REQ-016 SHALL have port fspu_fpr_wb_reg  output  5  FPR write index.
REQ-017 SHALL have port fspu_ctrl_full  output  1  buffer full; controller holds EX1.

Function
REQ-018 SHALL store {dst_reg, rst} in a circular FIFO of DEPTH entries with rd/wr pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-019 SHALL push when fspu_ex1_rtu_wb_vld && !fspu_ctrl_full && !rtu_yy_xx_flush.
REQ-020 SHALL ignore fspu_ex1_rtu_wb_vld while full, including a same-cycle pop; the controller re-presents the held EX1 result.
REQ-021 SHALL drive fspu_rtu_wb_vld = (count != 0), with data/reg taken from the head entry.
REQ-022 SHALL pop on fspu_rtu_wb_vld && rtu_fspu_wb_grant; grant with vld low has no effect.
REQ-023 SHALL keep head data/reg stable while vld is high and grant is low.
REQ-024 SHALL, on simultaneous push and pop with 0<count<DEPTH, leave count unchanged and advance both pointers.
REQ-025 SHALL drive fspu_ctrl_full = (count == DEPTH), a registered-state decode.
REQ-026 SHALL, on rtu_yy_xx_flush, empty the FIFO next cycle; flush overrides same-cycle push and pop. A grant in the flush cycle still completes that cycle's handshake at RTU.
REQ-027 SHALL register the float path one cycle: fspu_fpr_wb_vld <= fspu_ex1_dp_wb_vld && !rtu_yy_xx_flush; data/reg <= EX1 values when fspu_ex1_dp_wb_vld, else held.
REQ-028 SHALL apply no backpressure to the float path.
REQ-029 SHALL give integer latency of one cycle from push to fspu_rtu_wb_vld when empty.

Reset
REQ-030 SHALL, on cpurst, clear pointers, count, fspu_rtu_wb_vld, fspu_fpr_wb_vld and fspu_ctrl_full to 0, and clear data/reg outputs to 0.
REQ-031 SHALL let reset override flush, push and pop; inputs arriving in the reset cycle are discarded.

Configuration
REQ-032 SHALL support macro FSPU_WB_BYPASS_EN: when defined, with FIFO empty, push and grant in the same cycle, the result drives fspu_rtu_wb_* combinationally and is not enqueued (zero latency).
REQ-033 SHALL, with FSPU_WB_BYPASS_EN undefined, have no combinational path from EX1 inputs to fspu_rtu_wb_*.

Structure
REQ-034 SHALL take the entry width (37), the register-index width (5) and the DEPTH default from the shared FPU package.
REQ-035 SHALL instantiate one sub-module, pa_fspu_wb_fifo (storage, pointers, count), with the float register and bypass mux in the top.

Verification
REQ-036 SHALL cover: push 0x0000_0200 reg 5 with grant high -> fspu_rtu_wb_vld=1 next cycle, data 0x200, reg 5, popped that cycle.
REQ-037 SHALL cover: grant low, push A=0x1, B=0x2 -> full=1 after second push; third push C ignored; grant -> A, then B; C absent.
REQ-038 SHALL cover: count=1, simultaneous push and pop -> count stays 1, output order preserved.
REQ-039 SHALL cover: two entries held, flush plus push -> next cycle vld=0, full=0, pushed entry lost.
REQ-040 SHALL cover: fspu_ex1_dp_wb_vld with 0x8000_0000 reg 3 -> next cycle fspu_fpr_wb_vld=1, data 0x8000_0000, reg 3; the same input during flush -> vld=0.
REQ-041 SHALL cover: with FSPU_WB_BYPASS_EN, FIFO empty, push plus grant -> fspu_rtu_wb_vld same cycle and count stays 0.
